// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with a write-pending scoreboard.
// Two combinational read ports, one synchronous write-back port and a busy
// vector that marks the destinations of in-flight instructions. It flags
// read-after-write hazards (busy1/busy2) and write-after-write hazards
// (issue_ready) to the control unit.
// Optional feature: define RF_BYPASS_EN for same-cycle write-to-read forwarding.
module reg_file_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic [ADDR_W-1:0] a3,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_enable,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dest,
  output logic              issue_ready,
  output logic              busy1,
  output logic              busy2,
  output logic              stall,
  output logic [ADDR_W:0]   pending_count
);

  localparam int unsigned NREGS = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic zr_a1, zr_a2, zr_a3, zr_dest;
  logic wr_ok, iss_ok, cnt_inc, cnt_dec;
  logic fwd1, fwd2;

  // Zero-register detection per address port.
  always_comb begin
    zr_a1   = ZERO_REG && (a1 == '0);
    zr_a2   = ZERO_REG && (a2 == '0);
    zr_a3   = ZERO_REG && (a3 == '0);
    zr_dest = ZERO_REG && (issue_dest == '0);
  end

  // Issue acceptance and effective write/set strobes.
  always_comb begin
    issue_ready = !issue_valid || !busy_q[issue_dest] || zr_dest;
    wr_ok       = write_enable && !zr_a3;
    iss_ok      = issue_valid && issue_ready && !zr_dest;
    // A refused issue to a busy register can never collide with its clear,
    // so a set to a clear bit always counts up; a clear counts down unless
    // the same register is re-set this cycle.
    cnt_inc     = iss_ok && !busy_q[issue_dest];
    cnt_dec     = wr_ok && busy_q[a3] && !(iss_ok && (issue_dest == a3));
  end

  // Next state: write data, then clear on write-back, then set on issue.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_ok) begin
      regs_d[a3] = write_data;
      busy_d[a3] = 1'b0;
    end
    if (iss_ok) begin
      busy_d[issue_dest] = 1'b1;
    end
    count_d = count_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      regs_q  <= regs_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  // Forwarding selects for the two read ports.
  always_comb begin
`ifdef RF_BYPASS_EN
    fwd1 = wr_ok && (a3 == a1);
    fwd2 = wr_ok && (a3 == a2);
`else
    fwd1 = 1'b0;
    fwd2 = 1'b0;
`endif
  end

  // Combinational read ports and hazard flags.
  always_comb begin
    read_data1    = zr_a1 ? '0 : (fwd1 ? write_data : regs_q[a1]);
    read_data2    = zr_a2 ? '0 : (fwd2 ? write_data : regs_q[a2]);
    busy1         = busy_q[a1] && !zr_a1 && !fwd1;
    busy2         = busy_q[a2] && !zr_a2 && !fwd2;
    stall         = busy1 || busy2 || (issue_valid && !issue_ready);
    pending_count = count_q;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb (default parameters).
module tb_reg_file_sb;

  logic        clk;
  logic        reset;
  logic [4:0]  a1, a2, a3, issue_dest;
  logic [31:0] read_data1, read_data2, write_data;
  logic        write_enable, issue_valid;
  logic        issue_ready, busy1, busy2, stall;
  logic [5:0]  pending_count;

  int errors = 0;
  int checks = 0;

  reg_file_sb dut (
    .clk          (clk),
    .reset        (reset),
    .a1           (a1),
    .a2           (a2),
    .read_data1   (read_data1),
    .read_data2   (read_data2),
    .a3           (a3),
    .write_data   (write_data),
    .write_enable (write_enable),
    .issue_valid  (issue_valid),
    .issue_dest   (issue_dest),
    .issue_ready  (issue_ready),
    .busy1        (busy1),
    .busy2        (busy2),
    .stall        (stall),
    .pending_count(pending_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; a1 = '0; a2 = '0; a3 = '0; write_data = '0;
    write_enable = 1'b0; issue_valid = 1'b0; issue_dest = '0;
    #1;
    check("rst_rd1", read_data1, 32'h0);
    check("rst_rd2", read_data2, 32'h0);
    check("rst_busy1", 32'(busy1), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_ready", 32'(issue_ready), 32'h1);
    check("rst_count", 32'(pending_count), 32'h0);
    step(); step();
    reset = 1'b1;
    step();

    // Plain write and read, zero register on port 2.
    a3 = 5'd7; write_data = 32'h1234_5678; write_enable = 1'b1;
    step();
    write_enable = 1'b0; a1 = 5'd7; a2 = 5'd0;
    #1;
    check("wr7_rd1", read_data1, 32'h1234_5678);
    check("wr7_rd2_zero", read_data2, 32'h0);
    check("wr7_count", 32'(pending_count), 32'h0);

    // Write to register 0 is ignored.
    a3 = 5'd0; write_data = 32'hFFFF_FFFF; write_enable = 1'b1;
    step();
    write_enable = 1'b0; a1 = 5'd0;
    #1;
    check("wr0_rd1", read_data1, 32'h0);

    // Issue to 9 marks it busy.
    issue_valid = 1'b1; issue_dest = 5'd9;
    #1;
    check("iss9_ready", 32'(issue_ready), 32'h1);
    step();
    issue_valid = 1'b0; a1 = 5'd9;
    #1;
    check("iss9_busy1", 32'(busy1), 32'h1);
    check("iss9_stall", 32'(stall), 32'h1);
    check("iss9_count", 32'(pending_count), 32'h1);

    // WAW: second issue to busy 9 is refused.
    issue_valid = 1'b1; issue_dest = 5'd9;
    #1;
    check("waw9_ready", 32'(issue_ready), 32'h0);
    check("waw9_stall", 32'(stall), 32'h1);
    step();
    check("waw9_count", 32'(pending_count), 32'h1);

    // Issue to register 0 is accepted but sets nothing.
    issue_dest = 5'd0;
    #1;
    check("iss0_ready", 32'(issue_ready), 32'h1);
    step();
    issue_valid = 1'b0; a2 = 5'd0;
    #1;
    check("iss0_count", 32'(pending_count), 32'h1);
    check("iss0_busy2", 32'(busy2), 32'h0);

    // Write-back to 9 retires it.
    a1 = 5'd9; a3 = 5'd9; write_data = 32'h0000_00A5; write_enable = 1'b1;
    #1;
`ifdef RF_BYPASS_EN
    check("wb9_same_rd1", read_data1, 32'h0000_00A5);
    check("wb9_same_busy1", 32'(busy1), 32'h0);
`else
    check("wb9_same_rd1", read_data1, 32'h0);
    check("wb9_same_busy1", 32'(busy1), 32'h1);
`endif
    step();
    write_enable = 1'b0;
    #1;
    check("wb9_busy1", 32'(busy1), 32'h0);
    check("wb9_count", 32'(pending_count), 32'h0);
    check("wb9_rd1", read_data1, 32'h0000_00A5);

    // Issue 4, then write-back 4 together with issue 6.
    issue_valid = 1'b1; issue_dest = 5'd4;
    step();
    check("iss4_count", 32'(pending_count), 32'h1);
    issue_dest = 5'd6; a3 = 5'd4; write_data = 32'h0000_0044; write_enable = 1'b1;
    step();
    issue_valid = 1'b0; write_enable = 1'b0; a1 = 5'd4; a2 = 5'd6;
    #1;
    check("mix_count", 32'(pending_count), 32'h1);
    check("mix_busy4", 32'(busy1), 32'h0);
    check("mix_busy6", 32'(busy2), 32'h1);
    check("mix_rd4", read_data1, 32'h0000_0044);

    // Same-register issue and write-back on a clear bit: set wins.
    issue_valid = 1'b1; issue_dest = 5'd10;
    a3 = 5'd10; write_data = 32'h0000_1010; write_enable = 1'b1;
    step();
    a1 = 5'd10;
    #1;
    check("same10_busy", 32'(busy1), 32'h1);
    check("same10_count", 32'(pending_count), 32'h2);
    // Now busy: issue refused, only the clear applies.
    check("same10b_ready", 32'(issue_ready), 32'h0);
    write_data = 32'h0000_2020;
    step();
    issue_valid = 1'b0; write_enable = 1'b0;
    #1;
    check("same10b_busy", 32'(busy1), 32'h0);
    check("same10b_count", 32'(pending_count), 32'h1);
    check("same10b_rd", read_data1, 32'h0000_2020);

    // Forwarding on a non-busy register; count unchanged by the write.
    a3 = 5'd3; write_data = 32'h0000_0011; write_enable = 1'b1;
    step();
    a1 = 5'd3; write_data = 32'h0000_0055;
    #1;
`ifdef RF_BYPASS_EN
    check("byp3_rd1", read_data1, 32'h0000_0055);
`else
    check("byp3_rd1", read_data1, 32'h0000_0011);
`endif
    check("byp3_busy1", 32'(busy1), 32'h0);
    step();
    write_enable = 1'b0;
    #1;
    check("byp3_rd1_next", read_data1, 32'h0000_0055);
    check("byp3_count", 32'(pending_count), 32'h1);

    // Mid-run asynchronous reset.
    a3 = 5'd31; write_data = 32'hDEAD_BEEF; write_enable = 1'b1;
    issue_valid = 1'b1; issue_dest = 5'd5;
    step();
    write_enable = 1'b0; issue_valid = 1'b0; a1 = 5'd31; a2 = 5'd5;
    #1;
    check("pre_rst_rd31", read_data1, 32'hDEAD_BEEF);
    check("pre_rst_busy5", 32'(busy2), 32'h1);
    check("pre_rst_count", 32'(pending_count), 32'h2);
    #1;
    reset = 1'b0;
    #1;
    check("arst_rd31", read_data1, 32'h0);
    check("arst_busy5", 32'(busy2), 32'h0);
    check("arst_count", 32'(pending_count), 32'h0);
    check("arst_ready", 32'(issue_ready), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised register file with an integrated write-pending scoreboard.
- Intended for the multi-cycle/pipelined successor of the single-cycle MIPS datapath.
- Two combinational read ports and one synchronous write-back port.
- Tracks destination registers of in-flight instructions and flags read-after-write and write-after-write hazards to the control unit.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; NREGS = 2**ADDR_W registers.
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never marked busy.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- a1  input  ADDR_W  read port 1 address.
- a2  input  ADDR_W  read port 2 address.
- read_data1  output  DATA_W  read port 1 data (combinational).
- read_data2  output  DATA_W  read port 2 data (combinational).
- a3  input  ADDR_W  write-back address.
- write_data  input  DATA_W  write-back data.
- write_enable  input  1  write-back strobe; also retires the pending entry for a3.
- issue_valid  input  1  an instruction with destination issue_dest is issuing.
- issue_dest  input  ADDR_W  destination register of the issuing instruction.
- issue_ready  output  1  issue accepted this cycle (no WAW hazard).
- busy1  output  1  a1 has a pending write.
- busy2  output  1  a2 has a pending write.
- stall  output  1  busy1 | busy2 | (issue_valid & !issue_ready).
- pending_count  output  ADDR_W+1  number of set busy bits.

Behaviour:
- Reset (reset=0, asynchronous, independent of clk):
  - All NREGS registers cleared to 0, including the top register.
  - All busy bits cleared; pending_count=0.
  - Outputs then read_data1/2=0, busy1/2=0, stall=0, issue_ready=1 (given issue_valid=0).
- Reads: read_data1 = reg[a1], read_data2 = reg[a2], zero latency. With ZERO_REG=1, address 0 always reads 0.
- Write: on a rising edge with write_enable=1, reg[a3] <= write_data and busy[a3] <= 0. Ignored when ZERO_REG=1 and a3=0. A write to a non-busy register is legal: data is written and the count is unchanged.
- Issue acceptance: issue_ready = !issue_valid | !busy[issue_dest] | (ZERO_REG & issue_dest==0).
  - Accepted issue (issue_valid & issue_ready, dest not the zero register) sets busy[issue_dest] on the next edge.
  - An issue to a busy destination is refused: no state change, issue_ready=0.
- Simultaneous issue and write-back to the same register in one cycle: the write data is stored, then the set wins, so busy stays 1. issue_ready follows the busy value before the edge (0 when already busy, so the issue is refused and only the clear applies).
- pending_count: +1 on an accepted set of a clear bit, -1 on a clear of a set bit, net 0 when both occur on different registers. Never wraps; it is bounded by NREGS (or NREGS-1 with ZERO_REG).
- busy1 = busy[a1], busy2 = busy[a2] (modified by the bypass feature below). Both are 0 for address 0 with ZERO_REG=1.
- No internal FSM beyond the busy vector. The state is the register array, the busy vector and the counter.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If write_enable=1 and a3==a1 (and not the zero register), read_data1=write_data and busy1=0 in the same cycle. The same applies to a2.
  - Removes one stall cycle on write-back.
- Undefined: reads return only stored values, and busy1/busy2 reflect the stored busy bits. Consumers see new data one cycle after write-back.

Test Plan:
- Assert reset=0 mid-run after writing reg[31]=0xDEADBEEF and issuing to reg 5 -> immediately read_data(31)=0, busy1=0, pending_count=0, with no clock edge needed.
- Write 0x12345678 to reg 7, then read a1=7 and a2=0 -> read_data1=0x12345678, read_data2=0. Then write 0xFFFFFFFF to reg 0 -> reg 0 still reads 0.
- Issue dest 9 -> next cycle busy for a1=9 is 1, stall=1, pending_count=1. Write-back to 9 with 0xA5 -> next cycle busy1=0, pending_count=0, read_data1=0xA5.
- With reg 9 busy, issue dest 9 -> issue_ready=0, stall=1, pending_count unchanged. Issue dest 0 -> issue_ready=1 and no busy bit set.
- Same cycle: write-back to reg 4 (busy) and issue to reg 6 -> pending_count unchanged, busy[4]=0, busy[6]=1.
- RF_BYPASS_EN defined: a1=3, write_enable=1, a3=3, write_data=0x55 -> same cycle read_data1=0x55, busy1=0. Undefined: read_data1 = old value until the next cycle.
